cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
Run/step/halt sequencer for the pipelined MIPS core's clock. It sits between the board clock and the CPU. It produces a programmable-rate single-cycle clock enable (cpu_en) and a 50% divided clock (cpu_clk) for display/LED use. Debounced single-step button, CPU halt request and mode select decide when the core advances.

Parameters:
DIV_WIDTH, 16, width of divisor register and divide counter
DEFAULT_DIV, 100, divisor loaded at reset (period in clk cycles between cpu_en pulses)
DB_CYCLES, 1000, cycles the synchronized step button must be stable before its debounced level changes
CNT_WIDTH, 32, width of retired-enable counter

Ports:
clk  in  1  board clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
mode  in  2  requested mode: 00 idle, 01 run, 10 step, 11 reserved (treated as 00)
div_load  in  1  one-cycle strobe; latch div_value
div_value  in  DIV_WIDTH  new divisor
step_btn  in  1  raw asynchronous push button, active-high
halt_req  in  1  level from CPU (e.g. break/syscall decode); stops run mode
cpu_en  out  1  one-clk-wide advance pulse for the CPU pipeline registers
cpu_clk  out  1  toggles on every cpu_en
state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
en_count  out  CNT_WIDTH  number of cpu_en pulses issued, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cpu_en=0, cpu_clk=0, en_count=0, divisor=DEFAULT_DIV, divide counter=0, synchronizer/debounce regs=0, step_pend=0.
- Divisor: effective period P = max(divisor,1). On div_load, divisor<=div_value and divide counter<=0 in the same edge; no cpu_en is issued that cycle.
- Divide counter runs only in RUN. It counts 0..P-1. When it equals P-1 and state==RUN and halt_req==0, the block registers cpu_en=1 for exactly one cycle and the counter wraps to 0. First pulse arrives P cycles after entering RUN. With P=1, cpu_en is high every cycle.
- Step input: 2-FF synchronizer, then debounce. The debounced level changes only after the synchronized value has differed from it for DB_CYCLES consecutive cycles; any bounce restarts the count. A rising edge of the debounced level sets step_pend.
- In STEP with step_pend=1: cpu_en=1 on the next edge, step_pend cleared. Exactly one pulse per press. A press arriving while step_pend=1 is merged into the pending step, not queued. step_pend is cleared whenever state is not STEP, so no stale presses are kept.
- FSM, evaluated each edge, priority top-down:
  - any state, mode==00/11 -> IDLE
  - RUN, halt_req=1 -> HALTED. A cpu_en due on this same cycle is suppressed.
  - HALTED stays HALTED while mode==01, even after halt_req drops. Leaving HALTED requires passing through IDLE.
  - IDLE, mode==01 -> RUN (divide counter <=0); IDLE, mode==10 -> STEP
  - RUN, mode==10 -> STEP; STEP, mode==01 -> RUN (counter <=0)
  - HALTED, mode==10 -> STEP (single-step past a breakpoint allowed; halt_req ignored in STEP)
- cpu_clk<=~cpu_clk on every cycle cpu_en is registered high. It holds its value in IDLE/HALTED.
- en_count increments by 1 per cpu_en. It saturates at all-ones and is cleared only by reset.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then mode=01, div default 100 -> first cpu_en 100 clks after entering RUN, then every 100 clks. cpu_clk toggles with each pulse. en_count=3 after the third pulse.
- div_load div_value=0 while RUN -> counter cleared, cpu_en every cycle from the next cycle. Then div_value=4 -> pulses 4 clks apart.
- mode=10, step_btn bouncing (5 toggles of 10 clks each) then held high 2000 clks, DB_CYCLES=1000 -> exactly one cpu_en about 1002 clks after the stable high. No pulse on release.
- RUN, halt_req=1 on the cycle a pulse is due -> no cpu_en, state=11. halt_req=0 with mode still 01 -> remains 11. mode=00 then 01 -> RUN resumes, first pulse P clks later.
- HALTED, mode=10, one debounced press -> one cpu_en despite halt_req=1, state=10.
- rst_n asserted mid-RUN, asynchronous to clk -> all outputs 0 and state 00 immediately. divisor back to 100 after release.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt clock-enable sequencer for the pipelined MIPS core.
// Emits a rate-programmable one-cycle cpu_en, a toggling cpu_clk and a saturating pulse count.
module cpu_clk_ctrl #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 100,
    parameter int unsigned DB_CYCLES   = 1000,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 step_btn,
    input  logic                 halt_req,
    output logic                 cpu_en,
    output logic                 cpu_clk,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] en_count
);

    localparam int unsigned DbWidth = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [DbWidth-1:0] DbLast = DbWidth'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StHalted = 2'b11
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic [DIV_WIDTH-1:0]   w_cnt_next;
    logic [DIV_WIDTH-1:0]   w_last;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_db;
    logic [DbWidth-1:0]     r_db_cnt;
    logic                   w_db_rise;
    logic                   r_step_pend;
    logic                   w_step_pend_next;
    logic                   r_cpu_en;
    logic                   w_en_next;
    logic                   r_cpu_clk;
    logic [CNT_WIDTH-1:0]   r_en_count;
    logic                   w_mode_run;
    logic                   w_mode_step;

    assign w_mode_run  = (mode == 2'b01);
    assign w_mode_step = (mode == 2'b10);

    // A divisor of zero behaves as one: count limit is max(div,1)-1.
    assign w_last    = (r_div == '0) ? '0 : r_div - DIV_WIDTH'(1);
    assign w_db_rise = r_sync2 & ~r_db & (r_db_cnt == DbLast);

    always_comb begin
        w_state_next = r_state;
        if (!w_mode_run && !w_mode_step) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:   w_state_next = w_mode_run ? StRun : StStep;
                StRun: begin
                    if (halt_req)         w_state_next = StHalted;
                    else if (w_mode_step) w_state_next = StStep;
                end
                StStep:   if (w_mode_run) w_state_next = StRun;
                StHalted: if (w_mode_step) w_state_next = StStep;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_en_next        = 1'b0;
        w_cnt_next       = r_cnt;
        w_step_pend_next = 1'b0;
        if (r_state == StRun) begin
            if (r_cnt == w_last) begin
                w_cnt_next = '0;
                w_en_next  = ~halt_req & ~div_load;
            end else begin
                w_cnt_next = r_cnt + DIV_WIDTH'(1);
            end
        end
        // A new press while a step is pending merges into it.
        if (r_state == StStep) begin
            if (r_step_pend && !div_load) begin
                w_en_next = 1'b1;
            end else begin
                w_step_pend_next = r_step_pend | w_db_rise;
            end
        end
        if (w_state_next == StRun && r_state != StRun) begin
            w_cnt_next = '0;
        end
        if (div_load) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_div       <= DIV_WIDTH'(DEFAULT_DIV);
            r_cnt       <= '0;
            r_step_pend <= 1'b0;
            r_cpu_en    <= 1'b0;
            r_cpu_clk   <= 1'b0;
            r_en_count  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_step_pend <= w_step_pend_next;
            r_cpu_en    <= w_en_next;
            r_cpu_clk   <= r_cpu_clk ^ w_en_next;
            if (div_load) begin
                r_div <= div_value;
            end
            if (w_en_next && (r_en_count != '1)) begin
                r_en_count <= r_en_count + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= step_btn;
            r_sync2 <= r_sync1;
            // Level follows only after DB_CYCLES consecutive disagreeing samples.
            if (r_sync2 != r_db) begin
                if (r_db_cnt == DbLast) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DbWidth'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign cpu_en   = r_cpu_en;
    assign cpu_clk  = r_cpu_clk;
    assign state    = r_state;
    assign en_count = r_en_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: run rate, divisor reload, halt, debounced step, async reset.
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        div_load;
    logic [15:0] div_value;
    logic        step_btn;
    logic        halt_req;
    logic        cpu_en;
    logic        cpu_clk;
    logic [1:0]  state;
    logic [31:0] en_count;

    int n_cmp;
    int n_bad;

    cpu_clk_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .div_load  (div_load),
        .div_value (div_value),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .cpu_en    (cpu_en),
        .cpu_clk   (cpu_clk),
        .state     (state),
        .en_count  (en_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b00; div_load = 1'b0; div_value = '0;
        step_btn = 1'b0; halt_req = 1'b0;
        #12;
        n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", cpu_en); end
        n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL reset_clk: got %b want 0", cpu_clk); end
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", state); end
        n_cmp++; if (en_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", en_count); end
        rst_n = 1'b1;
        tick(150);
        n_cmp++; if (en_count !== 32'd0) begin n_bad++; $display("FAIL idle_count: got %0d want 0", en_count); end
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL idle_state: got %b want 00", state); end
    endtask

    task automatic test_run_default();
        int pulses;
        pulses = 0;
        mode = 2'b01;
        for (int k = 1; k <= 301; k++) begin
            tick(1);
            if (cpu_en) begin
                n_cmp++;
                if (k !== 101 + 100 * pulses) begin
                    n_bad++; $display("FAIL run_pulse_pos: got cycle %0d want %0d", k, 101 + 100 * pulses);
                end
                pulses++;
            end
        end
        n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL run_pulses: got %0d want 3", pulses); end
        n_cmp++; if (en_count !== 32'd3) begin n_bad++; $display("FAIL run_count: got %0d want 3", en_count); end
        n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL run_cpu_clk: got %b want 1", cpu_clk); end
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL run_state: got %b want 01", state); end
    endtask

    task automatic test_div_change();
        div_load = 1'b1; div_value = 16'd0;
        tick(1);
        n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL div0_load_en: got %b want 0", cpu_en); end
        div_load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("FAIL div0_en k=%0d: got %b want 1", k, cpu_en); end
        end
        div_load = 1'b1; div_value = 16'd4;
        tick(1);
        n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL div4_load_en: got %b want 0", cpu_en); end
        div_load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            n_cmp++;
            if (cpu_en !== ((k % 4) == 0)) begin
                n_bad++; $display("FAIL div4_en k=%0d: got %b want %b", k, cpu_en, (k % 4) == 0);
            end
        end
        n_cmp++; if (en_count !== 32'd11) begin n_bad++; $display("FAIL div_count: got %0d want 11", en_count); end
        n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL div_cpu_clk: got %b want 1", cpu_clk); end
    endtask

    task automatic test_halt();
        tick(3);
        halt_req = 1'b1;
        tick(1);
        n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL halt_suppress: got %b want 0", cpu_en); end
        n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL halt_state: got %b want 11", state); end
        halt_req = 1'b0;
        tick(5);
        n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL halt_hold: got %b want 11", state); end
        n_cmp++; if (en_count !== 32'd11) begin n_bad++; $display("FAIL halt_count: got %0d want 11", en_count); end
        mode = 2'b00;
        tick(1);
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL halt_to_idle: got %b want 00", state); end
        mode = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_cmp++;
            if (cpu_en !== (k == 5)) begin
                n_bad++; $display("FAIL resume_en k=%0d: got %b want %b", k, cpu_en, k == 5);
            end
        end
        n_cmp++; if (en_count !== 32'd12) begin n_bad++; $display("FAIL resume_count: got %0d want 12", en_count); end
        halt_req = 1'b1;
        tick(1);
        n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL rehalt_state: got %b want 11", state); end
    endtask

    task automatic test_step_halted();
        int pulses;
        int first_k;
        mode = 2'b10;
        tick(1);
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL step_state: got %b want 10", state); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step_btn = ((i % 2) == 0);
            for (int k = 0; k < 10; k++) begin
                tick(1);
                if (cpu_en) pulses++;
            end
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL bounce_pulses: got %0d want 0", pulses); end
        step_btn = 1'b1;
        first_k = -1;
        for (int k = 1; k <= 2000; k++) begin
            tick(1);
            if (cpu_en) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL press_pulses: got %0d want 1", pulses); end
        n_cmp++; if (first_k !== 1003) begin n_bad++; $display("FAIL press_latency: got %0d want 1003", first_k); end
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL press_state: got %b want 10", state); end
        n_cmp++; if (en_count !== 32'd13) begin n_bad++; $display("FAIL press_count: got %0d want 13", en_count); end
        n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL press_cpu_clk: got %b want 1", cpu_clk); end
        step_btn = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 1500; k++) begin
            tick(1);
            if (cpu_en) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL release_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_async_reset();
        int first_k;
        halt_req = 1'b0;
        mode = 2'b01;
        tick(3);
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL prereset_state: got %b want 01", state); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL areset_state: got %b want 00", state); end
        n_cmp++; if (en_count !== 32'd0) begin n_bad++; $display("FAIL areset_count: got %0d want 0", en_count); end
        n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL areset_clk: got %b want 0", cpu_clk); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL areset_en: got %b want 0", cpu_en); end
        #2 rst_n = 1'b1;
        first_k = -1;
        for (int k = 1; k <= 150; k++) begin
            tick(1);
            if (cpu_en && first_k < 0) first_k = k;
        end
        n_cmp++; if (first_k !== 101) begin n_bad++; $display("FAIL areset_div: got %0d want 101", first_k); end
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL areset_run: got %b want 01", state); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_run_default();
        test_div_change();
        test_halt();
        test_step_halted();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
